// File: rtl/inference_log_buf_pkg.sv
// -----------------------------------------------------------------------------
// inference_log_buf_pkg
// Shared definitions for the NPU inference result log buffer:
//   - default geometry (result width, address width, counter width)
//   - capture mode encodings
//   - register index map used when the buffer is wired into the
//     generic_regs software (sw) / hardware (hw) register vectors
// No ports (package).
// -----------------------------------------------------------------------------
package inference_log_buf_pkg;

    // Default geometry
    localparam int NPU_LOG_RESULT_WIDTH = 4;
    localparam int NPU_LOG_ADDR_WIDTH   = 4;
    localparam int NPU_LOG_CNT_WIDTH    = 32;

    // Capture mode encodings (sw_mode)
    localparam logic NPU_LOG_MODE_CIRC = 1'b0;  // overwrite oldest when full
    localparam logic NPU_LOG_MODE_STOP = 1'b1;  // drop new results when full

    // Software register vector: index of each field
    localparam int NPU_LOG_SW_REG_RD_ADDR = 0;
    localparam int NPU_LOG_SW_REG_CTRL    = 1;
    // Bit positions inside the control register
    localparam int NPU_LOG_CTRL_MODE_BIT   = 0;
    localparam int NPU_LOG_CTRL_FREEZE_BIT = 1;
    localparam int NPU_LOG_CTRL_CLEAR_BIT  = 2;

    // Hardware register vector: index of each field
    localparam int NPU_LOG_HW_REG_RD_DATA  = 0;
    localparam int NPU_LOG_HW_REG_COUNT    = 1;
    localparam int NPU_LOG_HW_REG_WR_PTR   = 2;
    localparam int NPU_LOG_HW_REG_TOTAL    = 3;
    localparam int NPU_LOG_HW_REG_OVERFLOW = 4;
    localparam int NPU_LOG_HW_REG_LAST     = 5;

endpackage

// File: rtl/inference_log_buf_log_dpram.sv
// -----------------------------------------------------------------------------
// log_dpram
// Simple dual-port RAM: one write port, one registered read port.
// Read-first: a read of the slot being written in the same cycle returns the
// old contents. Memory itself has no reset so it can map to block or
// distributed RAM; only the read output register is reset.
// Ports:
//   i_clk      clock
//   i_reset    synchronous active-high reset of the read output register
//   i_wr_en    write enable
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_addr  read address (sampled every cycle)
//   o_rd_data  registered read data, 1-cycle latency
// -----------------------------------------------------------------------------
module log_dpram
    import inference_log_buf_pkg::*;
#(
    parameter int RESULT_WIDTH = NPU_LOG_RESULT_WIDTH,
    parameter int ADDR_WIDTH   = NPU_LOG_ADDR_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_wr_en,
    input  logic [ADDR_WIDTH-1:0]   i_wr_addr,
    input  logic [RESULT_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0]   i_rd_addr,
    output logic [RESULT_WIDTH-1:0] o_rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [RESULT_WIDTH-1:0] r_mem [DEPTH];
    logic [RESULT_WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Non-blocking read of the array gives read-first behaviour.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/inference_log_buf.sv
// -----------------------------------------------------------------------------
// inference_log_buf
// Capture buffer for NPU inference results. Stores results on a qualified
// strobe in a DEPTH-entry ring, in circular or stop-when-full mode, with
// software freeze and edge-triggered clear. Exposes fill level, write pointer,
// saturating total/overflow counters, the last accepted result and a
// registered read port indexed relative to the oldest entry.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   res_valid     result strobe, one result per high cycle
//   res_data      result value
//   sw_rd_addr    read index relative to oldest entry
//   sw_mode       0 circular, 1 stop when full
//   sw_freeze     level, blocks writes (total still counts)
//   sw_clear      level, rising edge flushes buffer and counters
//   hw_rd_data    registered read data
//   hw_count      valid entries 0..DEPTH
//   hw_wr_ptr     next physical write slot
//   hw_total      strobes seen since reset/clear (saturating)
//   hw_overflow   results dropped or overwritten (saturating)
//   hw_last       most recent accepted result
// -----------------------------------------------------------------------------
module inference_log_buf
    import inference_log_buf_pkg::*;
#(
    parameter int RESULT_WIDTH = NPU_LOG_RESULT_WIDTH,
    parameter int ADDR_WIDTH   = NPU_LOG_ADDR_WIDTH,
    parameter int CNT_WIDTH    = NPU_LOG_CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    res_valid,
    input  logic [RESULT_WIDTH-1:0] res_data,
    input  logic [ADDR_WIDTH-1:0]   sw_rd_addr,
    input  logic                    sw_mode,
    input  logic                    sw_freeze,
    input  logic                    sw_clear,
    output logic [RESULT_WIDTH-1:0] hw_rd_data,
    output logic [ADDR_WIDTH:0]     hw_count,
    output logic [ADDR_WIDTH-1:0]   hw_wr_ptr,
    output logic [CNT_WIDTH-1:0]    hw_total,
    output logic [CNT_WIDTH-1:0]    hw_overflow,
    output logic [RESULT_WIDTH-1:0] hw_last
);

    localparam int                DEPTH = 2 ** ADDR_WIDTH;
    localparam int                CW    = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] FULL = CW'(DEPTH);

    logic                    r_clr_d;
    logic [ADDR_WIDTH:0]     r_count;
    logic [ADDR_WIDTH-1:0]   r_wr_ptr;
    logic [CNT_WIDTH-1:0]    r_total;
    logic [CNT_WIDTH-1:0]    r_overflow;
    logic [RESULT_WIDTH-1:0] r_last;

    logic                    w_clr_pulse;
    logic                    w_full;
    logic                    w_strobe;
    logic                    w_accept;
    logic                    w_write;
    logic                    w_ovf_evt;
    logic [ADDR_WIDTH-1:0]   w_oldest;
    logic [ADDR_WIDTH-1:0]   w_rd_addr;

    // Clear acts in the cycle sw_clear is first seen high; holding it high
    // does nothing more because r_clr_d is then also high.
    assign w_clr_pulse = sw_clear & ~r_clr_d;
    assign w_full      = (r_count == FULL);

    // A strobe in the clear cycle is discarded entirely (not even counted).
    assign w_strobe  = res_valid & ~w_clr_pulse;
    assign w_accept  = w_strobe & ~sw_freeze;
    // Stop mode drops the result when full; circular mode overwrites oldest.
    assign w_write   = w_accept & ~(w_full & (sw_mode == NPU_LOG_MODE_STOP));
    assign w_ovf_evt = w_accept & w_full;

    // With count == DEPTH the low bits are zero, so oldest == wr_ptr.
    assign w_oldest  = r_wr_ptr - r_count[ADDR_WIDTH-1:0];
    assign w_rd_addr = w_oldest + sw_rd_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_d    <= 1'b0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_total    <= '0;
            r_overflow <= '0;
            r_last     <= '0;
        end else begin
            r_clr_d <= sw_clear;
            if (w_clr_pulse) begin
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_total    <= '0;
                r_overflow <= '0;
                r_last     <= '0;
            end else begin
                if (w_write) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_last   <= res_data;
                    if (!w_full) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                if (w_ovf_evt && (r_overflow != '1)) begin
                    r_overflow <= r_overflow + 1'b1;
                end
                if (w_strobe && (r_total != '1)) begin
                    r_total <= r_total + 1'b1;
                end
            end
        end
    end

    log_dpram #(
        .RESULT_WIDTH (RESULT_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_mem (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_wr_en   (w_write),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (res_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (hw_rd_data)
    );

    assign hw_count    = r_count;
    assign hw_wr_ptr   = r_wr_ptr;
    assign hw_total    = r_total;
    assign hw_overflow = r_overflow;
    assign hw_last     = r_last;

endmodule

// File: tb/tb_inference_log_buf.sv
module tb_inference_log_buf;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset      = 1'b1;
  logic       res_valid  = 1'b0;
  logic [3:0] res_data   = '0;
  logic [3:0] sw_rd_addr = '0;
  logic       sw_mode    = 1'b0;
  logic       sw_freeze  = 1'b0;
  logic       sw_clear   = 1'b0;

  logic [3:0]  hw_rd_data;
  logic [4:0]  hw_count;
  logic [3:0]  hw_wr_ptr;
  logic [31:0] hw_total;
  logic [31:0] hw_overflow;
  logic [3:0]  hw_last;

  logic [3:0] s_rd_data;
  logic [4:0] s_count;
  logic [3:0] s_wr_ptr;
  logic [3:0] s_total;
  logic [3:0] s_overflow;
  logic [3:0] s_last;

  logic done = 1'b0;

  inference_log_buf dut (
    .clk         (clk),
    .reset       (reset),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .sw_rd_addr  (sw_rd_addr),
    .sw_mode     (sw_mode),
    .sw_freeze   (sw_freeze),
    .sw_clear    (sw_clear),
    .hw_rd_data  (hw_rd_data),
    .hw_count    (hw_count),
    .hw_wr_ptr   (hw_wr_ptr),
    .hw_total    (hw_total),
    .hw_overflow (hw_overflow),
    .hw_last     (hw_last)
  );

  inference_log_buf #(.CNT_WIDTH(4)) dut_small (
    .clk         (clk),
    .reset       (reset),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .sw_rd_addr  (sw_rd_addr),
    .sw_mode     (sw_mode),
    .sw_freeze   (sw_freeze),
    .sw_clear    (sw_clear),
    .hw_rd_data  (s_rd_data),
    .hw_count    (s_count),
    .hw_wr_ptr   (s_wr_ptr),
    .hw_total    (s_total),
    .hw_overflow (s_overflow),
    .hw_last     (s_last)
  );

  // ---------------- scoreboard ----------------
  localparam logic [7:0] K_COUNT   = 8'd0;
  localparam logic [7:0] K_PTR     = 8'd1;
  localparam logic [7:0] K_TOTAL   = 8'd2;
  localparam logic [7:0] K_OVF     = 8'd3;
  localparam logic [7:0] K_LAST    = 8'd4;
  localparam logic [7:0] K_RD      = 8'd5;
  localparam logic [7:0] K_S_OVF   = 8'd6;
  localparam logic [7:0] K_S_TOTAL = 8'd7;
  localparam logic [7:0] K_S_COUNT = 8'd8;

  // {kind[7:0], expected[31:0]}
  logic [39:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] actual(input logic [7:0] k);
    case (k)
      K_COUNT:   return 32'(hw_count);
      K_PTR:     return 32'(hw_wr_ptr);
      K_TOTAL:   return hw_total;
      K_OVF:     return hw_overflow;
      K_LAST:    return 32'(hw_last);
      K_RD:      return 32'(hw_rd_data);
      K_S_OVF:   return 32'(s_overflow);
      K_S_TOTAL: return 32'(s_total);
      K_S_COUNT: return 32'(s_count);
      default:   return 32'hdead_beef;
    endcase
  endfunction

  function automatic string kname(input logic [7:0] k);
    case (k)
      K_COUNT:   return "count";
      K_PTR:     return "wr_ptr";
      K_TOTAL:   return "total";
      K_OVF:     return "overflow";
      K_LAST:    return "last";
      K_RD:      return "rd_data";
      K_S_OVF:   return "small_overflow";
      K_S_TOTAL: return "small_total";
      K_S_COUNT: return "small_count";
      default:   return "unknown";
    endcase
  endfunction

  // Monitor: outputs are stable between edges; compare on the falling edge.
  logic [39:0] mon_e;
  logic [31:0] mon_act;
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = actual(mon_e[39:32]);
      n_tests++;
      if (mon_act !== mon_e[31:0]) begin
        n_fail++;
        $display("FAIL %s: got %0d expected %0d (t=%0t)",
                 kname(mon_e[39:32]), mon_act, mon_e[31:0], $time);
      end
    end
  end

  // Watchdog: fail if the stimulus does not complete in time.
  initial begin
    repeat (5000) @(posedge clk);
    if (!done) begin
      n_fail++;
      $display("FAIL timeout: stimulus did not finish (t=%0t)", $time);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string name, input logic [31:0] act,
                           input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic expect_val(input logic [7:0] k, input logic [31:0] v);
    exp_q.push_back({k, v});
  endtask

  task automatic expect_state(input int cnt, input int ptr, input int tot,
                              input int ovf, input int last);
    expect_val(K_COUNT, 32'(cnt));
    expect_val(K_PTR,   32'(ptr));
    expect_val(K_TOTAL, 32'(tot));
    expect_val(K_OVF,   32'(ovf));
    expect_val(K_LAST,  32'(last));
  endtask

  task automatic strobe(input logic [3:0] d);
    res_valid = 1'b1;
    res_data  = d;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic read_check(input logic [3:0] a, input logic [3:0] exp_d);
    sw_rd_addr = a;
    tick();
    expect_val(K_RD, 32'(exp_d));
  endtask

  task automatic do_clear();
    sw_clear = 1'b1;
    tick();
    sw_clear = 1'b0;
    tick();
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick();
    tick();
    reset = 1'b0;
    // Reset state
    check_now("reset count",          32'(hw_count),    32'd0);
    check_now("reset wr_ptr",         32'(hw_wr_ptr),   32'd0);
    check_now("reset total",          hw_total,         32'd0);
    check_now("reset overflow",       hw_overflow,      32'd0);
    check_now("reset last",           32'(hw_last),     32'd0);
    check_now("reset rd_data",        32'(hw_rd_data),  32'd0);
    check_now("reset small_total",    32'(s_total),     32'd0);
    check_now("reset small_overflow", 32'(s_overflow),  32'd0);
    expect_state(0, 0, 0, 0, 0);
    expect_val(K_RD, 32'd0);
    expect_val(K_S_TOTAL, 32'd0);
    expect_val(K_S_OVF, 32'd0);
    settle();

    // Five results in circular mode
    sw_mode = 1'b0;
    for (int i = 1; i <= 5; i++) strobe(4'(i));
    expect_state(5, 5, 5, 0, 5);
    settle();
    for (int i = 0; i < 5; i++) read_check(4'(i), 4'(i + 1));
    settle();

    // Circular wrap: 20 results, data i mod 16
    do_clear();
    sw_mode = 1'b0;
    for (int i = 0; i < 20; i++) strobe(4'(i));
    expect_state(16, 4, 20, 4, 3);
    settle();
    read_check(4'd0, 4'd4);
    read_check(4'd15, 4'd3);
    read_check(4'd11, 4'd15);
    settle();

    // Stop-when-full: 20 results, only first 16 kept
    do_clear();
    sw_mode = 1'b1;
    for (int i = 0; i < 20; i++) strobe(4'(i));
    expect_state(16, 0, 20, 4, 15);
    settle();
    read_check(4'd15, 4'd15);
    read_check(4'd0, 4'd0);
    settle();

    // Freeze blocks writes, total keeps counting
    do_clear();
    sw_mode = 1'b0;
    strobe(4'd10);
    strobe(4'd11);
    strobe(4'd12);
    sw_freeze = 1'b1;
    for (int i = 0; i < 3; i++) strobe(4'd9);
    expect_state(3, 3, 6, 0, 12);
    settle();
    sw_freeze = 1'b0;
    strobe(4'd7);
    expect_state(4, 4, 7, 0, 7);
    settle();
    read_check(4'd3, 4'd7);
    read_check(4'd2, 4'd12);
    settle();

    // Clear edge with coincident strobe, held high four cycles
    sw_clear  = 1'b1;
    res_valid = 1'b1;
    res_data  = 4'd5;
    tick();
    res_valid = 1'b0;
    expect_state(0, 0, 0, 0, 0);
    settle();
    tick();
    expect_val(K_COUNT, 32'd0);
    expect_val(K_TOTAL, 32'd0);
    settle();
    tick();
    strobe(4'd6);
    expect_state(1, 1, 1, 0, 6);
    settle();
    sw_clear = 1'b0;
    tick();
    read_check(4'd0, 4'd6);
    settle();

    // Saturation of narrow counters, stop mode, full buffer
    do_clear();
    sw_mode = 1'b1;
    for (int i = 0; i < 36; i++) strobe(4'(i));
    expect_state(16, 0, 36, 20, 15);
    expect_val(K_S_OVF, 32'd15);
    expect_val(K_S_TOTAL, 32'd15);
    expect_val(K_S_COUNT, 32'd16);
    settle();

    // Mode switch mid-run: next accept overwrites oldest
    sw_mode = 1'b0;
    strobe(4'd9);
    expect_state(16, 1, 37, 21, 9);
    expect_val(K_S_OVF, 32'd15);
    expect_val(K_S_TOTAL, 32'd15);
    settle();
    read_check(4'd15, 4'd9);
    read_check(4'd0, 4'd1);
    settle();

    tick();
    settle();
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
